time_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter downstream of the minutes/seconds countdown counters. It takes a snapshot of both 6-bit counter values on a sample strobe and converts each to two BCD digits with a serial shift-add-3 (double-dabble) datapath. It then presents four digit nibbles to the VGA character renderer, together with a one-cycle done pulse and an all-zero flag for the alarm/finish display.

---
 rtl/time_bcd_converter_pkg.sv | 17 +
 rtl/time_bcd_converter_dabble_step.sv | 23 ++
 rtl/time_bcd_converter.sv | 137 +++++++++++++
 tb/tb_time_bcd_converter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/time_bcd_converter_pkg.sv
// rtl/time_bcd_converter_pkg.sv - shared constants and state encoding for the time BCD converter
package time_bcd_converter_pkg;

  // Controller states: wait for a sample, convert seconds, convert minutes, publish
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEC  = 2'd1,
    ST_MIN  = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH  = 6;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ        = 3;
  localparam int MAX_TIME       = 59;

endpackage

// File: rtl/time_bcd_converter_dabble_step.sv
// rtl/time_bcd_converter_dabble_step.sv - one combinational double-dabble step on two BCD digits
module dabble_step
  import time_bcd_converter_pkg::*;
(
  input  logic [7:0] bcd_i,
  input  logic       bit_i,
  output logic [7:0] bcd_o
);

  logic [3:0] lo_adj;
  logic [3:0] hi_adj;

  // Pre-shift correction so a digit of 5..9 carries correctly once doubled
  always_comb begin
    lo_adj = bcd_i[3:0];
    hi_adj = bcd_i[7:4];
    if (bcd_i[3:0] >= 4'(BCD_ADJ_THRESH)) lo_adj = bcd_i[3:0] + 4'(BCD_ADJ);
    if (bcd_i[7:4] >= 4'(BCD_ADJ_THRESH)) hi_adj = bcd_i[7:4] + 4'(BCD_ADJ);
  end

  assign bcd_o = {hi_adj[2:0], lo_adj, bit_i};

endmodule

// File: rtl/time_bcd_converter.sv
// rtl/time_bcd_converter.sv - serial binary-to-BCD conversion of a minutes/seconds snapshot
module time_bcd_converter
  import time_bcd_converter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [WIDTH-1:0] sec_in,
  input  logic [WIDTH-1:0] min_in,
  output logic [3:0]       sec_ones,
  output logic [3:0]       sec_tens,
  output logic [3:0]       min_ones,
  output logic [3:0]       min_tens,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] sec_sh_q, sec_sh_d;
  logic [WIDTH-1:0] min_sh_q, min_sh_d;
  // Working copy shifted out MSB-first; the shadows stay intact for the zero test
  logic [WIDTH-1:0] work_q, work_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       sec_res_q, sec_res_d;
  logic [7:0]       sec_dig_q, sec_dig_d;
  logic [7:0]       min_dig_q, min_dig_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic [7:0]       step_bcd;

  dabble_step u_step (
    .bcd_i (acc_q),
    .bit_i (work_q[WIDTH-1]),
    .bcd_o (step_bcd)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      sec_sh_q  <= '0;
      min_sh_q  <= '0;
      work_q    <= '0;
      acc_q     <= '0;
      sec_res_q <= '0;
      sec_dig_q <= '0;
      min_dig_q <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      sec_sh_q  <= sec_sh_d;
      min_sh_q  <= min_sh_d;
      work_q    <= work_d;
      acc_q     <= acc_d;
      sec_res_q <= sec_res_d;
      sec_dig_q <= sec_dig_d;
      min_dig_q <= min_dig_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state sequencing: sample, WIDTH seconds steps, WIDTH minutes steps, publish
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    sec_sh_d  = sec_sh_q;
    min_sh_d  = min_sh_q;
    work_d    = work_q;
    acc_d     = acc_q;
    sec_res_d = sec_res_q;
    sec_dig_d = sec_dig_q;
    min_dig_d = min_dig_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          sec_sh_d = sec_in;
          min_sh_d = min_in;
          work_d   = sec_in;
          acc_d    = '0;
          step_d   = '0;
          state_d  = ST_SEC;
        end
      end
      ST_SEC: begin
        acc_d  = step_bcd;
        work_d = work_q << 1;
        step_d = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          sec_res_d = step_bcd;
          acc_d     = '0;
          work_d    = min_sh_q;
          step_d    = '0;
          state_d   = ST_MIN;
        end
      end
      ST_MIN: begin
        acc_d  = step_bcd;
        work_d = work_q << 1;
        step_d = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sec_dig_d = sec_res_q;
        min_dig_d = acc_q;
        zero_d    = (sec_sh_q == '0) && (min_sh_q == '0);
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sec_ones = sec_dig_q[3:0];
  assign sec_tens = sec_dig_q[7:4];
  assign min_ones = min_dig_q[3:0];
  assign min_tens = min_dig_q[7:4];
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_time_bcd_converter.sv
// tb/tb_time_bcd_converter.sv - scoreboard bench for the time BCD converter
module tb_time_bcd_converter;

  typedef struct {
    int st;
    int so;
    int mt;
    int mo;
    int z;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample = 1'b0;
  logic [5:0] sec_in = '0;
  logic [5:0] min_in = '0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       busy, done, zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   prev_done = 0;
  exp_t sb[$];

  time_bcd_converter #(.WIDTH(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .sample   (sample),
    .sec_in   (sec_in),
    .min_in   (min_in),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: each done pulse pops one expected result and compares it
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sec_tens", int'(sec_tens), e.st);
        chk("sec_ones", int'(sec_ones), e.so);
        chk("min_tens", int'(min_tens), e.mt);
        chk("min_ones", int'(min_ones), e.mo);
        chk("zero", int'(zero), e.z);
        chk("latency", cyc, e.due);
        chk("busy_in_done", int'(busy), 0);
      end
    end
    prev_done = int'(done);
  end

  // Drive one sample for a full cycle; the following posedge is E0
  task automatic issue(input logic [5:0] s, input logic [5:0] m, input bit push,
                       input int st, input int so, input int mt, input int mo, input int z);
    exp_t e;
    @(negedge clk);
    sample = 1'b1;
    sec_in = s;
    min_in = m;
    if (push) begin
      e.st = st; e.so = so; e.mt = mt; e.mo = mo; e.z = z;
      e.due = cyc + 1 + 13;
      sb.push_back(e);
    end
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_digits", int'({sec_tens, sec_ones, min_tens, min_ones}), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(6'd59, 6'd59, 1'b1, 5, 9, 5, 9, 0);
    repeat (20) @(negedge clk);

    issue(6'd7, 6'd42, 1'b1, 0, 7, 4, 2, 0);
    sec_in = 6'd0;
    min_in = 6'd0;
    repeat (3) @(negedge clk);
    sample = 1'b1;
    chk("busy_mid_conv", int'(busy), 1);
    @(negedge clk);
    sample = 1'b0;
    repeat (25) @(negedge clk);

    issue(6'd0, 6'd0, 1'b1, 0, 0, 0, 0, 1);
    repeat (20) @(negedge clk);

    issue(6'd63, 6'd60, 1'b1, 6, 3, 6, 0, 0);
    wait_done();
    begin
      exp_t e;
      sample = 1'b1;
      sec_in = 6'd5;
      min_in = 6'd30;
      e.st = 0; e.so = 5; e.mt = 3; e.mo = 0; e.z = 0;
      e.due = cyc + 1 + 13;
      sb.push_back(e);
    end
    @(negedge clk);
    sample = 1'b0;
    chk("busy_back_to_back", int'(busy), 1);
    repeat (20) @(negedge clk);

    issue(6'd11, 6'd22, 1'b0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_digits", int'({sec_tens, sec_ones, min_tens, min_ones}), 0);
    chk("abort_zero", int'(zero), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (25) @(negedge clk);

    chk("pending_results", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
